tb_virt_periph: RTL and testbench



---
 rtl/tb_virt_periph_pkg.sv | 31 +++
 rtl/tb_char_fifo.sv | 57 +++++
 rtl/tb_virt_periph.sv | 162 ++++++++++++++++
 tb/tb_tb_virt_periph.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_virt_periph_pkg.sv
// Shared constants and types for the virtual test peripheral that a simulated core
// uses for console output, pass/fail status and exit codes.
package tb_virt_periph_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CHAR_W = 8;

  localparam logic [DATA_W-1:0] ADDR_PRINT_DEF  = 32'h1000_0000;
  localparam logic [DATA_W-1:0] ADDR_STATUS_DEF = 32'h2000_0000;
  localparam logic [DATA_W-1:0] ADDR_EXIT_DEF   = 32'h2000_0004;
  localparam logic [DATA_W-1:0] ADDR_CYCLES_DEF = 32'h1500_1000;
  localparam logic [DATA_W-1:0] PASS_MAGIC_DEF  = 32'd123456789;
  localparam logic [DATA_W-1:0] FAIL_MAGIC_DEF  = 32'd1;

  // Registered data-port response
  typedef struct packed {
    logic              rvalid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PRINT,
    SEL_STATUS,
    SEL_EXIT,
    SEL_CYCLES
  } sel_e;

endpackage

// File: rtl/tb_char_fifo.sv
// First-word-fall-through character FIFO; pushes while full are dropped.
module tb_char_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;

  // Power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tb_virt_periph.sv
// Memory-mapped simulation peripheral: stdout character FIFO, sticky pass/fail and
// exit-code registers, and a free-running cycle counter on a single-cycle data port.
module tb_virt_periph
  import tb_virt_periph_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH  = 8,
  parameter logic [DATA_W-1:0] ADDR_PRINT  = ADDR_PRINT_DEF,
  parameter logic [DATA_W-1:0] ADDR_STATUS = ADDR_STATUS_DEF,
  parameter logic [DATA_W-1:0] ADDR_EXIT   = ADDR_EXIT_DEF,
  parameter logic [DATA_W-1:0] ADDR_CYCLES = ADDR_CYCLES_DEF,
  parameter logic [DATA_W-1:0] PASS_MAGIC  = PASS_MAGIC_DEF,
  parameter logic [DATA_W-1:0] FAIL_MAGIC  = FAIL_MAGIC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic [DATA_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  output logic              char_valid_o,
  output logic [CHAR_W-1:0] char_data_o,
  input  logic              char_ready_i,
  output logic              tests_passed_o,
  output logic              tests_failed_o,
  output logic              exit_valid_o,
  output logic [DATA_W-1:0] exit_value_o
);

  sel_e              sel;
  rsp_t              rsp_d;
  rsp_t              rsp_q;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              be_full;
  logic              set_pass;
  logic              set_fail;
  logic              set_exit;
  logic [DATA_W-1:0] cycle_q;
  logic              passed_q;
  logic              failed_q;
  logic              exit_valid_q;
  logic [DATA_W-1:0] exit_value_q;

  // Address decode
  always_comb begin
    sel = SEL_NONE;
    if (data_addr_i == ADDR_PRINT) begin
      sel = SEL_PRINT;
    end else if (data_addr_i == ADDR_STATUS) begin
      sel = SEL_STATUS;
    end else if (data_addr_i == ADDR_EXIT) begin
      sel = SEL_EXIT;
    end else if (data_addr_i == ADDR_CYCLES) begin
      sel = SEL_CYCLES;
    end
  end

  // A print write stalls while the FIFO is full, even if the head pops this cycle
  assign data_gnt_o = data_req_i & ~(data_we_i & (sel == SEL_PRINT) & fifo_full);
  assign be_full    = (data_be_i == {BE_W{1'b1}});
  assign pop        = char_valid_o & char_ready_i;

  // Response and side effects of a granted access
  always_comb begin
    rsp_d    = '0;
    push     = 1'b0;
    set_pass = 1'b0;
    set_fail = 1'b0;
    set_exit = 1'b0;
    if (data_gnt_o) begin
      rsp_d.rvalid = 1'b1;
      case (sel)
        SEL_PRINT: begin
          if (data_we_i) begin
            push      = data_be_i[0];
            rsp_d.err = ~data_be_i[0];
          end
        end
        SEL_STATUS: begin
          if (data_we_i) begin
            if (be_full) begin
              set_pass = (data_wdata_i == PASS_MAGIC);
              set_fail = (data_wdata_i == FAIL_MAGIC);
            end else begin
              rsp_d.err = 1'b1;
            end
          end
        end
        SEL_EXIT: begin
          if (data_we_i) begin
            if (be_full) begin
              set_exit = ~exit_valid_q;
            end else begin
              rsp_d.err = 1'b1;
            end
          end
        end
        SEL_CYCLES: begin
          if (data_we_i) begin
            rsp_d.err = 1'b1;
          end else begin
            rsp_d.rdata = cycle_q;
          end
        end
        default: rsp_d.err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q        <= '0;
      cycle_q      <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
    end else begin
      rsp_q   <= rsp_d;
      cycle_q <= cycle_q + DATA_W'(1);
      if (set_pass) begin
        passed_q <= 1'b1;
      end
      if (set_fail) begin
        failed_q <= 1'b1;
      end
      if (set_exit) begin
        exit_valid_q <= 1'b1;
        exit_value_q <= data_wdata_i;
      end
    end
  end

  tb_char_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(CHAR_W)
  ) u_char_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (data_wdata_i[CHAR_W-1:0]),
    .pop_i  (pop),
    .valid_o(char_valid_o),
    .data_o (char_data_o),
    .full_o (fifo_full)
  );

  assign data_rvalid_o  = rsp_q.rvalid;
  assign data_err_o     = rsp_q.err;
  assign data_rdata_o   = rsp_q.rdata;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_tb_virt_periph.sv
// Self-checking bench for tb_virt_periph: directed scenarios plus randomized accesses
// compared against a queue-based model of the peripheral.
module tb_tb_virt_periph;

  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] A_PRINT  = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h2000_0000;
  localparam logic [31:0] A_EXIT   = 32'h2000_0004;
  localparam logic [31:0] A_CYCLES = 32'h1500_1000;
  localparam logic [31:0] M_PASS   = 32'd123456789;
  localparam logic [31:0] M_FAIL   = 32'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;
  logic        passed;
  logic        failed;
  logic        exit_valid;
  logic [31:0] exit_value;

  always #5 clk = ~clk;

  tb_virt_periph #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .data_err_o    (err),
    .char_valid_o  (char_valid),
    .char_data_o   (char_data),
    .char_ready_i  (char_ready),
    .tests_passed_o(passed),
    .tests_failed_o(failed),
    .exit_valid_o  (exit_valid),
    .exit_value_o  (exit_value)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  logic [7:0]  mq[$];
  bit          m_pass;
  bit          m_fail;
  bit          m_exit_v;
  logic [31:0] m_exit_val;
  logic [31:0] tb_cyc;
  bit          pend_push;
  logic [7:0]  pend_char;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags();
    check("passed", 32'(passed), 32'(m_pass));
    check("failed", 32'(failed), 32'(m_fail));
    check("exit_valid", 32'(exit_valid), 32'(m_exit_v));
    check("exit_value", exit_value, m_exit_val);
  endtask

  // One clock: apply model effects of the edge, then check the FIFO head
  task automatic tick();
    bit pop_now;
    pop_now = (mq.size() != 0) && (char_ready == 1'b1);
    @(posedge clk);
    if (pop_now) void'(mq.pop_front());
    if (pend_push) begin
      mq.push_back(pend_char);
      pend_push = 1'b0;
    end
    tb_cyc = tb_cyc + 32'd1;
    @(negedge clk);
    check("char_valid", 32'(char_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("char_data", 32'(char_data), 32'(mq[0]));
  endtask

  task automatic model_clear();
    mq.delete();
    m_pass     = 1'b0;
    m_fail     = 1'b0;
    m_exit_v   = 1'b0;
    m_exit_val = '0;
    pend_push  = 1'b0;
    tb_cyc     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 1'b0; we = 1'b0; char_ready = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_passed", 32'(passed), 32'd0);
    check("rst_failed", 32'(failed), 32'd0);
    check("rst_exit_valid", 32'(exit_valid), 32'd0);
    check("rst_exit_value", exit_value, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("gnt_idle", 32'(gnt), 32'd0);
  endtask

  // One access; model predicts grant, response and side effects
  task automatic access(input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input bit idle, output logic [31:0] rd);
    bit          exp_g;
    bit          exp_err;
    logic [31:0] exp_rd;
    rd  = '0;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1;
    exp_g = !(w && a == A_PRINT && mq.size() == int'(DEPTH));
    check("gnt", 32'(gnt), 32'(exp_g));
    if (!exp_g) begin
      req = 1'b0; we = 1'b0;
      tick();
      #1;
      check("rvalid_blocked", 32'(rvalid), 32'd0);
      return;
    end
    exp_err = 1'b0;
    exp_rd  = '0;
    if (a == A_PRINT) begin
      if (w) begin
        if (b[0]) begin pend_push = 1'b1; pend_char = d[7:0]; end
        else exp_err = 1'b1;
      end
    end else if (a == A_STATUS) begin
      if (w) begin
        if (b == 4'hF) begin
          if (d == M_PASS) m_pass = 1'b1;
          if (d == M_FAIL) m_fail = 1'b1;
        end else exp_err = 1'b1;
      end
    end else if (a == A_EXIT) begin
      if (w) begin
        if (b == 4'hF) begin
          if (!m_exit_v) begin m_exit_v = 1'b1; m_exit_val = d; end
        end else exp_err = 1'b1;
      end
    end else if (a == A_CYCLES) begin
      if (w) exp_err = 1'b1;
      else exp_rd = tb_cyc;
    end else begin
      exp_err = 1'b1;
    end
    tick();
    req = 1'b0; we = 1'b0;
    #1;
    check("rvalid", 32'(rvalid), 32'd1);
    check("err", 32'(err), 32'(exp_err));
    check("rdata", rdata, exp_rd);
    rd = rdata;
    check_flags();
    if (idle) begin
      tick();
      #1;
      check("rvalid_idle", 32'(rvalid), 32'd0);
      check("err_idle", 32'(err), 32'd0);
      check("rdata_idle", rdata, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    model_clear();
    do_reset();

    // Two characters, consumer always ready, back-to-back grants
    char_ready = 1'b1;
    access(1'b1, A_PRINT, 4'hF, 32'h0000_0048, 1'b0, rd);
    access(1'b1, A_PRINT, 4'h1, 32'hABCD_EF69, 1'b1, rd);
    tick(); tick();

    // Fill the FIFO, ninth write stalls until a pop has happened
    do_reset();
    for (int i = 0; i < 8; i++) access(1'b1, A_PRINT, 4'hF, 32'(48 + i), 1'b1, rd);
    req = 1'b1; we = 1'b1; addr = A_PRINT; be = 4'hF; wdata = 32'h39;
    for (int i = 0; i < 3; i++) begin
      #1; check("gnt_full", 32'(gnt), 32'd0);
      tick();
    end
    char_ready = 1'b1;
    #1; check("gnt_full_pop", 32'(gnt), 32'd0);
    tick();
    char_ready = 1'b0;
    #1; check("gnt_after_pop", 32'(gnt), 32'd1);
    pend_push = 1'b1; pend_char = 8'h39;
    tick();
    req = 1'b0; we = 1'b0;
    #1;
    check("rvalid_9th", 32'(rvalid), 32'd1);
    check("err_9th", 32'(err), 32'd0);
    char_ready = 1'b1;
    repeat (9) tick();
    char_ready = 1'b0;
    access(1'b1, A_PRINT, 4'hE, 32'h41, 1'b1, rd);

    // Pass magic, exit code captured once
    do_reset();
    access(1'b1, A_STATUS, 4'hF, M_PASS, 1'b1, rd);
    repeat (3) tick();
    check_flags();
    access(1'b1, A_STATUS, 4'hF, 32'd77, 1'b1, rd);
    access(1'b1, A_EXIT, 4'hF, 32'd5, 1'b1, rd);
    access(1'b1, A_EXIT, 4'hF, 32'd7, 1'b1, rd);
    check("exit_hold", exit_value, 32'd5);
    access(1'b1, A_STATUS, 4'hF, M_FAIL, 1'b0, rd);
    access(1'b0, A_STATUS, 4'hF, 32'd0, 1'b1, rd);

    // Cycle counter read ten cycles after reset release
    do_reset();
    repeat (10) tick();
    access(1'b0, A_CYCLES, 4'hF, 32'd0, 1'b1, rd);
    check("cyc_at_10", rd, 32'd10);

    // Unmapped and partial-enable accesses
    access(1'b1, 32'h3000_0000, 4'hF, 32'd1234, 1'b1, rd);
    access(1'b0, 32'h3000_0000, 4'hF, 32'd0, 1'b1, rd);
    access(1'b1, A_EXIT, 4'h3, 32'd9, 1'b1, rd);
    access(1'b1, A_STATUS, 4'h7, M_PASS, 1'b1, rd);

    // Reset while a response is pending
    access(1'b1, A_PRINT, 4'hF, 32'h5A, 1'b0, rd);
    req = 1'b1; we = 1'b1; addr = A_PRINT; be = 4'hF; wdata = 32'h51;
    @(posedge clk);
    #2;
    req = 1'b0; we = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_char_valid", 32'(char_valid), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
    end

    // Randomized accesses against the model
    do_reset();
    for (int n = 0; n < 250; n++) begin
      int unsigned k;
      bit          w;
      logic [3:0]  b;
      logic [31:0] a;
      logic [31:0] d;
      k = $urandom_range(0, 6);
      w = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      d = $urandom;
      case (k)
        0, 1, 2: a = A_PRINT;
        3: begin
          a = A_STATUS;
          case ($urandom_range(0, 2))
            0:       d = M_PASS;
            1:       d = M_FAIL;
            default: ;
          endcase
        end
        4: a = A_EXIT;
        5: begin a = A_CYCLES; w = 1'b0; end
        default: a = 32'h3000_0000 | ($urandom & 32'h0000_FFFC);
      endcase
      char_ready = ($urandom_range(0, 2) == 0);
      access(w, a, b, d, ($urandom_range(0, 1) == 1), rd);
    end

    // Counter wrap from all-ones
    char_ready = 1'b1;
    force dut.cycle_q = 32'hFFFF_FFFF;
    tick();
    release dut.cycle_q;
    req = 1'b1; we = 1'b0; addr = A_CYCLES; be = 4'hF;
    tick();
    #1;
    check("cyc_max", rdata, 32'hFFFF_FFFF);
    tick();
    req = 1'b0;
    #1;
    check("cyc_wrap", rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
